// File: rtl/ram_loader_if.sv
// rtl/ram_loader_if.sv - nibble stream and RAM control bundle for ram_loader
// Purpose: groups the upstream valid/ready nibble stream and the 16x4 RAM
//          control/data lines into one bundle.
// Signals: in_valid, in_data   stream nibble and its valid (towards loader)
//          in_ready            loader accepts a nibble this cycle
//          ram_cs              RAM chip select, active-high
//          ram_write_en        RAM write enable, 0 = write, 1 = read
//          ram_addr, ram_wdata RAM address and write data
//          ram_rdata           RAM combinational read data (towards loader)
// Modports: master = loader side, slave = stream source / RAM side.
interface ram_loader_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              ram_cs;
   logic              ram_write_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      input  in_valid, in_data, ram_rdata,
      output in_ready, ram_cs, ram_write_en, ram_addr, ram_wdata
   );

   modport slave (
      output in_valid, in_data, ram_rdata,
      input  in_ready, ram_cs, ram_write_en, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - fills a 16x4 RAM from a nibble stream, optional verify pass
// Purpose: power-up preload of program/data RAM; an optional second pass of the
//          same stream is compared against RAM read-back.
// Ports:   clk, rst         clock, synchronous active-high reset
//          start, verify_en begin a sequence (IDLE/DONE); verify_en latched with start
//          bus              stream handshake + RAM control (ram_loader_if.master)
//          busy, done       LOAD/VERIFY in progress, sequence complete
//          error, err_addr  sticky verify mismatch and address of the first one
//          checksum         mod-2**DATA_W sum of the nibbles of the last load pass
module ram_loader #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              verify_en,
   ram_loader_if.master      bus,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] expected;
   logic              verify_lat;
   logic              final_pending;  // last verify read issued, its compare is this cycle
   logic              accept;
   logic              last_cell;

   assign accept    = bus.in_valid & bus.in_ready;
   assign last_cell = (count == ADDR_W'(DEPTH - 1));

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_next = S_LOAD;
         S_LOAD:         if (accept && last_cell) state_next = verify_lat ? S_VERIFY : S_DONE;
         S_VERIFY:       if (final_pending) state_next = S_DONE;
         default:        state_next = S_IDLE;
      endcase
   end

   // state-decoded outputs; in_ready drops during the final compare cycle so a
   // seventeenth nibble is never consumed
   always_comb begin
      bus.in_ready = (state == S_LOAD) || ((state == S_VERIFY) && !final_pending);
      busy         = (state == S_LOAD) || (state == S_VERIFY);
      done         = (state == S_DONE);
   end

   // registered RAM strobes and datapath; strobes default to idle every cycle so
   // ram_write_en can only be low together with ram_cs
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ram_cs       <= 1'b0;
         bus.ram_write_en <= 1'b1;
         bus.ram_addr     <= '0;
         bus.ram_wdata    <= '0;
         count            <= '0;
         expected         <= '0;
         verify_lat       <= 1'b0;
         final_pending    <= 1'b0;
         error            <= 1'b0;
         err_addr         <= '0;
         checksum         <= '0;
      end else begin
         bus.ram_cs       <= 1'b0;
         bus.ram_write_en <= 1'b1;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  count         <= '0;
                  error         <= 1'b0;
                  err_addr      <= '0;
                  checksum      <= '0;
                  verify_lat    <= verify_en;
                  final_pending <= 1'b0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  bus.ram_cs       <= 1'b1;
                  bus.ram_write_en <= 1'b0;
                  bus.ram_addr     <= count;
                  bus.ram_wdata    <= bus.in_data;
                  checksum         <= checksum + bus.in_data;
                  count            <= count + 1'b1;
               end
            end
            S_VERIFY: begin
               // a read strobe presented this cycle is checked against the
               // nibble captured when it was issued; the write strobe left over
               // from the last load beat is excluded by ram_write_en
               if (bus.ram_cs && bus.ram_write_en && (bus.ram_rdata != expected) && !error) begin
                  error    <= 1'b1;
                  err_addr <= bus.ram_addr;
               end
               if (accept) begin
                  bus.ram_cs       <= 1'b1;
                  bus.ram_addr     <= count;
                  expected         <= bus.in_data;
                  count            <= count + 1'b1;
                  if (last_cell) final_pending <= 1'b1;
               end
               if (final_pending) final_pending <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader with a behavioural RAM
module tb_ram_loader;
   logic       clk = 1'b0;
   logic       rst, start, verify_en;
   logic       busy, done, error;
   logic [3:0] err_addr, checksum;

   int checks = 0;
   int errors = 0;

   ram_loader_if #(.DATA_W(4), .ADDR_W(4)) bus ();

   ram_loader #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .verify_en(verify_en), .bus(bus),
      .busy(busy), .done(done), .error(error), .err_addr(err_addr), .checksum(checksum)
   );

   always #5 clk = ~clk;

   // behavioural RAM; fault_en makes cells 5 and 9 read back 0x3
   logic [3:0] mem [16];
   bit         fault_en;
   always @(posedge clk)
      if (bus.ram_cs && !bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_wdata;
   assign bus.ram_rdata = (fault_en && bus.ram_write_en && (bus.ram_addr == 4'd5 || bus.ram_addr == 4'd9))
                          ? 4'h3 : mem[bus.ram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], rd_addr_q[$], rd_cyc_q[$], acc_cyc_q[$];
   int viol = 0;
   bit done_hist [int];

   always @(negedge clk) begin
      if (bus.ram_cs && !bus.ram_write_en) begin
         wr_addr_q.push_back(int'(bus.ram_addr));
         wr_data_q.push_back(int'(bus.ram_wdata));
         wr_cyc_q.push_back(cyc);
      end
      if (bus.ram_cs && bus.ram_write_en) begin
         rd_addr_q.push_back(int'(bus.ram_addr));
         rd_cyc_q.push_back(cyc);
      end
      if (!bus.ram_cs && !bus.ram_write_en) viol++;
      done_hist[cyc] = done;
   end

   localparam logic [21:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};

   function automatic logic [21:0] out_vec();
      return {bus.in_ready, bus.ram_cs, bus.ram_write_en, bus.ram_addr, bus.ram_wdata,
              busy, done, error, err_addr, checksum};
   endfunction

   // reference model: checksum is the wrapped sum; first mismatch is the first
   // cell whose read-back differs from the second-pass nibble
   function automatic logic [3:0] model_sum(input logic [3:0] d [16]);
      int s = 0;
      for (int k = 0; k < 16; k++) s += int'(d[k]);
      return 4'(s % 16);
   endfunction

   function automatic void model_verify(input logic [3:0] d1 [16], input logic [3:0] d2 [16],
                                        input bit fault, output bit err, output int ea);
      logic [3:0] rb;
      err = 0; ea = 0;
      for (int k = 0; k < 16; k++) begin
         rb = (fault && (k == 5 || k == 9)) ? 4'h3 : d1[k];
         if (rb != d2[k] && !err) begin err = 1; ea = k; end
      end
   endfunction

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      rd_addr_q.delete(); rd_cyc_q.delete(); acc_cyc_q.delete();
   endtask

   // mode 0 continuous, 1 every other cycle, 2 random gaps; start pulsed while idx == start_at
   task automatic run_pass(input logic [3:0] d [16], input int mode, input int start_at);
      int idx = 0;
      int guard = 0;
      bit v;
      while (idx < 16 && guard < 400) begin
         @(negedge clk);
         guard++;
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid = v;
         bus.in_data  = d[idx];
         start        = (idx == start_at);
         if (v && bus.in_ready) begin acc_cyc_q.push_back(cyc); idx++; end
      end
      start = 1'b0;
      checks++;
      if (idx < 16) begin errors++; $display("FAIL stream_accept: accepted %0d required 16", idx); end
   endtask

   task automatic wait_done();
      int guard = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         guard++;
      end while (!done && guard < 40);
      checks++;
      if (!done) begin errors++; $display("FAIL done_timeout: done %0b required 1", done); end
      @(negedge clk); #1;
   endtask

   task automatic do_seq(input bit ver, input logic [3:0] d1 [16], input logic [3:0] d2 [16],
                         input int mode, input int start_at);
      clear_logs();
      @(negedge clk); start = 1'b1; verify_en = ver;
      @(negedge clk); start = 1'b0; verify_en = ~ver;  // must already be latched
      run_pass(d1, mode, start_at);
      if (ver) run_pass(d2, mode, -1);
      wait_done();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_vec() !== RESET_VEC) begin errors++; $display("FAIL reset_in: got %h required %h", out_vec(), RESET_VEC); end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (out_vec() !== RESET_VEC) begin errors++; $display("FAIL reset_idle: got %h required %h", out_vec(), RESET_VEC); end
   endtask

   task automatic test_load_continuous();
      logic [3:0] d [16];
      int last;
      for (int k = 0; k < 16; k++) d[k] = 4'(k);
      do_seq(1'b0, d, d, 0, -1);
      checks++;
      if (wr_addr_q.size() != 16 || rd_addr_q.size() != 0) begin
         errors++; $display("FAIL cont_count: writes %0d reads %0d required 16 0", wr_addr_q.size(), rd_addr_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_addr_q[k] != k || wr_data_q[k] != k || wr_cyc_q[k] != wr_cyc_q[0] + k) begin
               errors++; $display("FAIL cont_write%0d: addr %0d data %0d gap %0d required %0d %0d %0d",
                                  k, wr_addr_q[k], wr_data_q[k], wr_cyc_q[k] - wr_cyc_q[0], k, k, k);
            end
         end
         last = wr_cyc_q[15];
         checks++;
         if (done_hist[last + 1] !== 1'b1) begin errors++; $display("FAIL cont_done_after: got %0b required 1", done_hist[last + 1]); end
      end
      checks++;
      if ({checksum, done, busy, bus.in_ready} !== {4'h8, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL cont_final: cks %h done %0b busy %0b rdy %0b required 8 1 0 0", checksum, done, busy, bus.in_ready);
      end
   endtask

   task automatic test_load_gapped();
      logic [3:0] d [16];
      for (int k = 0; k < 16; k++) d[k] = 4'(k);
      for (int k = 0; k < 16; k++) mem[k] = 4'hF - 4'(k);
      do_seq(1'b0, d, d, 1, -1);
      checks++;
      if (wr_addr_q.size() != 16 || acc_cyc_q.size() != 16) begin
         errors++; $display("FAIL gap_count: writes %0d accepts %0d required 16 16", wr_addr_q.size(), acc_cyc_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_cyc_q[k] != acc_cyc_q[k] + 1 || wr_addr_q[k] != k || mem[k] != 4'(k)) begin
               errors++; $display("FAIL gap_write%0d: cyc %0d addr %0d mem %0d required %0d %0d %0d",
                                  k, wr_cyc_q[k], wr_addr_q[k], mem[k], acc_cyc_q[k] + 1, k, k);
            end
         end
      end
      checks++;
      if (checksum !== 4'h8) begin errors++; $display("FAIL gap_checksum: got %h required 8", checksum); end
   endtask

   task automatic test_verify_pass();
      logic [3:0] d [16];
      for (int k = 0; k < 16; k++) d[k] = 4'hA;
      do_seq(1'b1, d, d, 0, -1);
      checks++;
      if (wr_addr_q.size() != 16 || rd_addr_q.size() != 16 || acc_cyc_q.size() != 32) begin
         errors++; $display("FAIL vfy_count: writes %0d reads %0d required 16 16", wr_addr_q.size(), rd_addr_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (rd_addr_q[k] != k || rd_cyc_q[k] != acc_cyc_q[16 + k] + 1 || rd_cyc_q[k] <= wr_cyc_q[15]) begin
               errors++; $display("FAIL vfy_read%0d: addr %0d cyc %0d required %0d %0d", k, rd_addr_q[k], rd_cyc_q[k], k, acc_cyc_q[16 + k] + 1);
            end
         end
      end
      checks++;
      if ({error, done, checksum} !== {1'b0, 1'b1, 4'h0}) begin
         errors++; $display("FAIL vfy_final: err %0b done %0b cks %h required 0 1 0", error, done, checksum);
      end
   endtask

   task automatic test_verify_fault_and_restart();
      logic [3:0] d [16];
      logic [3:0] r [16];
      int guard;
      for (int k = 0; k < 16; k++) d[k] = 4'(k);
      fault_en = 1'b1;
      do_seq(1'b1, d, d, 2, -1);
      fault_en = 1'b0;
      checks++;
      if ({error, err_addr, checksum} !== {1'b1, 4'h5, 4'h8}) begin
         errors++; $display("FAIL fault_final: err %0b addr %0d cks %h required 1 5 8", error, err_addr, checksum);
      end
      // start from DONE clears the sticky status
      @(negedge clk); start = 1'b1; verify_en = 1'b0;
      @(negedge clk); start = 1'b0; #1;
      checks++;
      if ({busy, bus.in_ready, error, err_addr, checksum} !== {1'b1, 1'b1, 1'b0, 4'h0, 4'h0}) begin
         errors++; $display("FAIL restart_clear: busy %0b rdy %0b err %0b addr %0d cks %h required 1 1 0 0 0",
                            busy, bus.in_ready, error, err_addr, checksum);
      end
      for (int k = 0; k < 16; k++) r[k] = 4'($urandom);
      run_pass(r, 2, -1);
      wait_done();
      checks++;
      if (checksum !== model_sum(r)) begin errors++; $display("FAIL restart_checksum: got %h required %h", checksum, model_sum(r)); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] d [16];
      int acc = 0;
      int guard = 0;
      clear_logs();
      @(negedge clk); start = 1'b1; verify_en = 1'b1;
      @(negedge clk); start = 1'b0;
      while (acc < 7 && guard < 100) begin
         @(negedge clk);
         guard++;
         bus.in_valid = 1'b1;
         bus.in_data  = 4'($urandom);
         if (bus.in_ready) acc++;
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (out_vec() !== RESET_VEC) begin errors++; $display("FAIL midrst_outputs: got %h required %h", out_vec(), RESET_VEC); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (wr_addr_q.size() != 7 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_nowrite: writes %0d busy %0b required 7 0", wr_addr_q.size(), busy);
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 16; k++) d[k] = 4'($urandom);
      do_seq(1'b0, d, d, 0, -1);
      checks++;
      if (wr_addr_q.size() != 16 || wr_addr_q[0] != 0 || wr_addr_q[15] != 15) begin
         errors++; $display("FAIL midrst_reload: writes %0d first %0d required 16 0", wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : -1);
      end
   endtask

   task automatic test_start_ignored();
      logic [3:0] d [16];
      for (int k = 0; k < 16; k++) d[k] = 4'($urandom);
      do_seq(1'b0, d, d, 2, 6);
      checks++;
      if (wr_addr_q.size() != 16) begin
         errors++; $display("FAIL busy_start_count: writes %0d required 16", wr_addr_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_addr_q[k] != k || wr_data_q[k] != int'(d[k])) begin
               errors++; $display("FAIL busy_start_write%0d: addr %0d data %0d required %0d %0d", k, wr_addr_q[k], wr_data_q[k], k, d[k]);
            end
         end
      end
      checks++;
      if (checksum !== model_sum(d)) begin errors++; $display("FAIL busy_start_checksum: got %h required %h", checksum, model_sum(d)); end
   endtask

   task automatic test_random();
      logic [3:0] d1 [16];
      logic [3:0] d2 [16];
      bit ver, exp_err;
      int exp_ea;
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 16; k++) begin d1[k] = 4'($urandom); d2[k] = d1[k]; end
         ver = (it % 3 != 2);
         if (it % 2 == 1) begin
            d2[$urandom_range(0, 15)] ^= 4'($urandom_range(1, 15));
            d2[$urandom_range(0, 15)] ^= 4'($urandom_range(1, 15));
         end
         do_seq(ver, d1, d2, 2, -1);
         model_verify(d1, d2, 1'b0, exp_err, exp_ea);
         if (!ver) begin exp_err = 0; exp_ea = 0; end
         checks++;
         if ({error, err_addr, checksum} !== {exp_err, 4'(exp_ea), model_sum(d1)}) begin
            errors++; $display("FAIL rand%0d_status: err %0b addr %0d cks %h required %0b %0d %h",
                               it, error, err_addr, checksum, exp_err, exp_ea, model_sum(d1));
         end
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (mem[k] !== d1[k]) begin errors++; $display("FAIL rand%0d_mem%0d: got %h required %h", it, k, mem[k], d1[k]); end
         end
         checks++;
         if (rd_addr_q.size() != (ver ? 16 : 0)) begin
            errors++; $display("FAIL rand%0d_reads: got %0d required %0d", it, rd_addr_q.size(), ver ? 16 : 0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; verify_en = 1'b0; fault_en = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = 4'h0;
      for (int k = 0; k < 16; k++) mem[k] = 4'h0;
      test_reset();
      test_load_continuous();
      test_load_gapped();
      test_verify_pass();
      test_verify_fault_and_restart();
      test_reset_mid();
      test_start_ignored();
      test_random();
      checks++;
      if (viol != 0) begin errors++; $display("FAIL we_without_cs: cycles %0d required 0", viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Upstream stage of the 4-bit computer's 16x4 RAM. Fills all 16 RAM cells from a nibble stream using a valid/ready handshake.
- Can optionally verify the contents: a second pass of the same stream is compared against RAM read-back.
- Drives the RAM control lines directly:
  - chip select, active-high.
  - write enable, active-low write: 0 = write, 1 = read.
  - address and write data.
- Used at power-up to preload program/data memory before the CPU runs.

Parameters:
- DATA_W, 4, nibble width of stream and RAM data.
- ADDR_W, 4, RAM address width.
- DEPTH, 16, number of cells loaded per pass. Must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a load sequence when sampled high in IDLE or DONE.
- verify_en  input  1  sampled with start; 1 = run verify pass after load.
- in_valid  input  1  stream nibble valid.
- in_data  input  DATA_W  stream nibble.
- in_ready  output  1  loader can accept a nibble this cycle.
- ram_cs  output  1  RAM chip select.
- ram_write_en  output  1  RAM write enable, active-low write.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  data to RAM data input.
- ram_rdata  input  DATA_W  data from RAM data output; combinational read.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  high in DONE.
- error  output  1  sticky verify mismatch flag.
- err_addr  output  ADDR_W  address of first mismatch.
- checksum  output  DATA_W  mod-16 sum of all nibbles written in the last load pass.

Behaviour:
- Reset: clk and rst are decided; rst is synchronous, active-high, one clock. Reset values:
  - state = IDLE.
  - in_ready = 0, ram_cs = 0, ram_write_en = 1, ram_addr = 0, ram_wdata = 0.
  - busy = 0, done = 0, error = 0, err_addr = 0, checksum = 0.
  - Internal count = 0.
- Reset mid-operation aborts immediately to reset values. No further RAM access occurs.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - in_ready = 0; RAM idle (cs = 0, write_en = 1).
  - On start = 1: go to LOAD; clear count, error, err_addr, checksum; latch verify_en.
- LOAD:
  - in_ready = 1 combinationally while in LOAD.
  - Accept = in_valid & in_ready.
  - On accept in cycle N, registered outputs in cycle N+1: ram_cs = 1, ram_write_en = 0, ram_addr = count, ram_wdata = in_data.
  - checksum += in_data (wraps mod 16); count increments.
  - Cycles with no accept: ram_cs = 0, ram_write_en = 1. Back-to-back accepts give back-to-back writes (1 write per cycle).
  - On the accept with count = DEPTH-1: go to VERIFY if verify_en is latched, else DONE. count wraps to 0.
- VERIFY:
  - in_ready = 1. On accept in cycle N, in cycle N+1: ram_cs = 1, ram_write_en = 1 (read), ram_addr = count. The expected nibble is held internally.
  - At the end of cycle N+1, ram_rdata is compared with the expected nibble.
  - On the first mismatch: error <= 1 and err_addr <= that address. Later mismatches do not overwrite err_addr.
  - After the DEPTH-th accept and its compare cycle complete: go to DONE. The final compare is included in error before done rises.
- DONE:
  - done = 1, busy = 0, in_ready = 0, RAM idle. error, err_addr and checksum hold.
  - start = 1 restarts as from IDLE (same clears and latching).
- start is ignored while busy.
- in_valid when in_ready = 0 is ignored; the nibble is not consumed.
- ram_write_en is never 0 while ram_cs = 0.
- ram_wdata holds its last value when not writing.

Test Plan:
- Reset then start, verify_en = 0, stream 0x0..0xF with in_valid continuous:
  - 16 consecutive write cycles, addr k gets data k.
  - checksum = 0x8 (sum 120 mod 16).
  - done = 1 on the cycle after the last write; in_ready = 0 afterward.
- Same load with in_valid gapped every other cycle:
  - Writes occur only on the cycle after each accept; ram_cs = 0 in the gaps.
  - Final RAM contents are unchanged from the continuous case.
- verify_en = 1, stream 0xA repeated 16x, RAM model correct:
  - 16 writes, then 16 reads at addr 0..15.
  - error = 0, done = 1, checksum = 0x0.
- verify_en = 1, RAM model forces addr 5 and addr 9 to read 0x3 during verify:
  - error = 1, err_addr = 5 at done.
- Assert rst during LOAD after 7 writes:
  - Next cycle all outputs are at reset values; no further writes.
  - A new start reloads from addr 0.
- start pulsed during LOAD: no effect on count or addresses. start in DONE: new sequence begins, error and checksum cleared.
